wb_select_reg: RTL and testbench
================================

# wb_select_reg

Parametrised writeback stage for the pipelined mini-CPU. It replaces the two-input ALU/memory writeback multiplexer with a registered MEM/WB boundary. It selects one of `NSRC` result sources, extracts and sign- or zero-extends sub-word loads, and presents a one-cycle-latency register-file write port with stall, flush, an illegal-select flag and a retired-write counter.

## Interface
- `XLEN`, default 32: datapath width; must be ≥ 32.
- `NSRC`, default 4: number of result sources, range 2–8. Source 0 is ALU, 1 is MEM, 2 is LINK (PC+4), 3 is IMM; indices ≥ 4 pass through unchanged.
- `REGW`, default 5: register-number width.
- `CNTW`, default 32: retire-counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the MEM/WB register.
- `flush`  in  1  kill the incoming instruction.
- `in_valid`  in  1  MEM-stage instruction valid.
- `in_wreg`  in  1  instruction writes the register file.
- `in_rn`  in  REGW  destination register.
- `in_sel`  in  3  source index.
- `in_ld_size`  in  2  load size: 0 byte, 1 half, 2 word, 3 treated as word.
- `in_ld_unsigned`  in  1  zero-extend sub-word loads.
- `in_byte_off`  in  2  address bits [1:0] of the load.
- `in_src`  in  NSRC*XLEN  flattened sources; source k is at [k*XLEN +: XLEN].
- `wb_valid`  out  1  registered instruction valid.
- `wb_we`  out  1  register-file write enable.
- `wb_rn`  out  REGW  register-file write address.
- `wb_data`  out  XLEN  register-file write data.
- `sel_err`  out  1  sticky flag: illegal `in_sel` seen.
- `retired`  out  CNTW  count of committed register writes.

## Operation
- **Combinational front end:**
  - Choose `in_src[in_sel]`.
  - If `in_sel` ≥ `NSRC`, choose source 0 and raise the illegal condition.
- **Load extraction (applies only when `in_sel` = 1):**
  - Byte: lane `in_byte_off`, little-endian.
  - Half: lane `in_byte_off[1]`; `in_byte_off[0]` is ignored.
  - Word: bits [31:0].
  - Result is sign-extended to XLEN unless `in_ld_unsigned` is set, in which case it is zero-extended.
- **Write suppression:** `we_next = in_valid & in_wreg & (in_rn != 0)`. Register 0 is never written.
- **MEM/WB register update, evaluated each rising edge in priority order:**
  1. `flush`: `wb_valid` ← 0 and `wb_we` ← 0; `wb_rn` and `wb_data` are don't-care but are cleared to 0.
  2. Else `stall`: all `wb_*` hold.
  3. Else load `in_valid`, `we_next`, `in_rn` and the selected data.
- **`sel_err`:**
  - Set on any edge that loads (not flushed, not stalled) an instruction with `in_valid` = 1 and an illegal `in_sel`.
  - Cleared only by `rst`.
- **`retired`:**
  - Increments by 1 on each edge that loads `we_next` = 1.
  - Wraps modulo 2^CNTW.
  - Does not count during stall or flush.

## Timing
- Latency from input to `wb_*` is 1 cycle.
- `wb_*` outputs are purely registered.
- During reset (`rst` asserted), all outputs are 0: `wb_valid`, `wb_we`, `wb_rn`, `wb_data`, `sel_err` and `retired`. Reset takes effect immediately, independent of `clk`.
- Reset asserted mid-stall discards the held instruction.
- First load occurs on the first rising edge after `rst` deasserts.
- When `flush` and `stall` are asserted together, flush wins and the register clears.
- A stalled `wb_we` = 1 stays asserted. The register-file write repeats with identical data (idempotent) and is counted once.
- `in_*` inputs are don't-care while `stall` or `flush` is asserted.

## Structure
- **Shared package `cpu_pkg`:**
  - Source-index constants `SRC_ALU` = 0, `SRC_MEM` = 1, `SRC_LINK` = 2, `SRC_IMM` = 3.
  - Load-size constants `LD_B`, `LD_H`, `LD_W`.
- **Sub-module `load_extract`:** purely combinational load-extraction logic (`XLEN` parameter; inputs data, size, unsigned, byte_off).
- **Top level:** source multiplexer, MEM/WB register, counter and sticky flag.

## Test plan
- **Source select.** `in_sel` = 0, ALU = 0x0000_1234, `in_rn` = 5, valid, wreg.
  - Next edge: `wb_data` = 0x0000_1234, `wb_rn` = 5, `wb_we` = 1, `retired` = 1.
- **Load extraction.** `in_sel` = 1, MEM = 0x80FF_7F81.
  - Byte, offset 0, signed → 0xFFFF_FF81.
  - Same with unsigned → 0x0000_0081.
  - Half, offset 2, signed → 0xFFFF_80FF.
  - Word → 0x80FF_7F81.
- **Register 0 suppression.** `in_rn` = 0 with wreg = 1.
  - `wb_we` = 0, `wb_valid` = 1, `retired` unchanged.
- **Stall then flush.** Load instruction A, then `stall` for 3 cycles with different inputs.
  - `wb_*` hold A and `retired` increments once.
  - Then `flush` + `stall` together: `wb_valid` = 0 and `wb_we` = 0 next edge.
- **Illegal select.** `in_sel` = 6 with `NSRC` = 4, valid.
  - `wb_data` = source 0 and `sel_err` = 1, and `sel_err` stays set across later legal instructions until `rst`.
- **Wrap and reset.** `CNTW` = 4; commit 17 writes.
  - `retired` = 1.
  - Then assert `rst` asynchronously between edges: all outputs are 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-CPU pipeline.
//   src_e    : writeback source indices (indices >= 4 pass through unchanged)
//   ld_size_e: load size encodings (3 behaves as a word load)
package cpu_pkg;

    typedef enum logic [2:0] {
        SRC_ALU  = 3'd0,
        SRC_MEM  = 3'd1,
        SRC_LINK = 3'd2,
        SRC_IMM  = 3'd3
    } src_e;

    typedef enum logic [1:0] {
        LD_B     = 2'd0,
        LD_H     = 2'd1,
        LD_W     = 2'd2,
        LD_W_ALT = 2'd3
    } ld_size_e;

endpackage

// File: rtl/load_extract.sv
// Combinational load extraction: picks the addressed byte/half/word lane of a
// little-endian memory word and sign- or zero-extends it to XLEN.
// Ports:
//   data        in  XLEN  raw memory read data (word in bits [31:0])
//   size        in  2     load size (byte, half, word; 3 acts as word)
//   ld_unsigned in  1     zero-extend instead of sign-extend
//   byte_off    in  2     address bits [1:0]
//   result      out XLEN  extended load value
module load_extract
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (byte_off)
            2'd0:    byte_lane = data[7:0];
            2'd1:    byte_lane = data[15:8];
            2'd2:    byte_lane = data[23:16];
            default: byte_lane = data[31:24];
        endcase
        // Half-word lane follows byte_off[1] only; misaligned bit 0 is ignored.
        half_lane = byte_off[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        result = '0;
        unique case (size)
            LD_B: begin
                result       = {XLEN{~ld_unsigned & byte_lane[7]}};
                result[7:0]  = byte_lane;
            end
            LD_H: begin
                result       = {XLEN{~ld_unsigned & half_lane[15]}};
                result[15:0] = half_lane;
            end
            default: begin
                result       = {XLEN{~ld_unsigned & data[31]}};
                result[31:0] = data[31:0];
            end
        endcase
    end

endmodule

// File: rtl/wb_select_reg.sv
// Registered MEM/WB writeback stage: source multiplexer, load extraction,
// register-file write port with stall/flush, sticky illegal-select flag and a
// retired-write counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall, flush    hold / kill the MEM/WB register (flush wins)
//   in_valid        MEM-stage instruction valid
//   in_wreg, in_rn  writes the register file / destination register
//   in_sel          source index; >= NSRC selects source 0 and flags sel_err
//   in_ld_size, in_ld_unsigned, in_byte_off  load extraction controls (sel 1)
//   in_src          flattened sources, source k at [k*XLEN +: XLEN]
//   wb_valid, wb_we, wb_rn, wb_data  registered write port
//   sel_err         sticky illegal-select flag, cleared only by rst
//   retired         count of committed register writes, wraps
module wb_select_reg
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NSRC = 4,
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_wreg,
    input  logic [REGW-1:0]      in_rn,
    input  logic [2:0]           in_sel,
    input  logic [1:0]           in_ld_size,
    input  logic                 in_ld_unsigned,
    input  logic [1:0]           in_byte_off,
    input  logic [NSRC*XLEN-1:0] in_src,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [REGW-1:0]      wb_rn,
    output logic [XLEN-1:0]      wb_data,
    output logic                 sel_err,
    output logic [CNTW-1:0]      retired
);

    localparam logic [3:0] NsrcW = 4'(NSRC);

    logic            sel_illegal;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] data_next;
    logic            we_next;
    logic            load;

    logic            valid_q, valid_d;
    logic            we_q, we_d;
    logic [REGW-1:0] rn_q, rn_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign sel_illegal = ({1'b0, in_sel} >= NsrcW);

    always_comb begin
        src_data = in_src[int'(SRC_ALU)*XLEN +: XLEN];
        for (int k = 0; k < int'(NSRC); k++) begin
            if (in_sel == 3'(k)) begin
                src_data = in_src[k*XLEN +: XLEN];
            end
        end
    end

    load_extract #(
        .XLEN(XLEN)
    ) u_load_extract (
        .data       (in_src[int'(SRC_MEM)*XLEN +: XLEN]),
        .size       (in_ld_size),
        .ld_unsigned(in_ld_unsigned),
        .byte_off   (in_byte_off),
        .result     (ld_data)
    );

    assign data_next = (in_sel == SRC_MEM) ? ld_data : src_data;
    assign we_next   = in_valid & in_wreg & (in_rn != '0);
    assign load      = ~flush & ~stall;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rn_d    = rn_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rn_d    = '0;
            data_d  = '0;
        end else if (load) begin
            valid_d = in_valid;
            we_d    = we_next;
            rn_d    = in_rn;
            data_d  = data_next;
            if (in_valid && sel_illegal) begin
                err_d = 1'b1;
            end
            // A stalled write is counted once, when it is first loaded.
            if (we_next) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rn_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rn_q    <= rn_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_we    = we_q;
    assign wb_rn    = rn_q;
    assign wb_data  = data_q;
    assign sel_err  = err_q;
    assign retired  = cnt_q;

endmodule

// File: tb/tb_wb_select_reg.sv
module tb_wb_select_reg;

    localparam int XLEN = 32;
    localparam int NSRC = 4;
    localparam int REGW = 5;
    localparam int CNTW = 4;

    logic                 clk;
    logic                 rst;
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic                 in_wreg;
    logic [REGW-1:0]      in_rn;
    logic [2:0]           in_sel;
    logic [1:0]           in_ld_size;
    logic                 in_ld_unsigned;
    logic [1:0]           in_byte_off;
    logic [NSRC*XLEN-1:0] in_src;
    logic                 wb_valid;
    logic                 wb_we;
    logic [REGW-1:0]      wb_rn;
    logic [XLEN-1:0]      wb_data;
    logic                 sel_err;
    logic [CNTW-1:0]      retired;

    int checks = 0;
    int errors = 0;
    logic [CNTW-1:0] exp_ret = '0;

    wb_select_reg #(
        .XLEN(XLEN),
        .NSRC(NSRC),
        .REGW(REGW),
        .CNTW(CNTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_wreg       (in_wreg),
        .in_rn         (in_rn),
        .in_sel        (in_sel),
        .in_ld_size    (in_ld_size),
        .in_ld_unsigned(in_ld_unsigned),
        .in_byte_off   (in_byte_off),
        .in_src        (in_src),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rn         (wb_rn),
        .wb_data       (wb_data),
        .sel_err       (sel_err),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_srcs(input logic [31:0] s0, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] s3);
        in_src = {s3, s2, s1, s0};
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rn,
                         input logic [2:0] sel, input logic [1:0] sz, input logic u,
                         input logic [1:0] off);
        in_valid       = v;
        in_wreg        = w;
        in_rn          = rn;
        in_sel         = sel;
        in_ld_size     = sz;
        in_ld_unsigned = u;
        in_byte_off    = off;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({wb_valid, wb_we, wb_rn, wb_data, sel_err, retired} !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b we=%b rn=%0d data=%h err=%b ret=%0d, expected all 0",
                     name, wb_valid, wb_we, wb_rn, wb_data, sel_err, retired);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 3'd0, 2'd2, 1'b0, 2'd0);
        set_srcs(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        #3;
        check_all_zero("reset_async");
        step();
        check_all_zero("reset_held_over_edge");
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_source_select();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h0000_1234;
        exp_d[1] = 32'h80FF_7F81;
        exp_d[2] = 32'h0000_0104;
        exp_d[3] = 32'hDEAD_BEEF;
        set_srcs(exp_d[0], exp_d[1], exp_d[2], exp_d[3]);
        drive(1'b1, 1'b1, 5'd5, 3'd0, 2'd2, 1'b0, 2'd0);
        step();
        exp_ret++;
        checks++;
        if (wb_data !== 32'h0000_1234 || wb_rn !== 5'd5 || wb_we !== 1'b1 ||
            wb_valid !== 1'b1 || retired !== 4'd1) begin
            errors++;
            $display("FAIL src_alu: got data=%h rn=%0d we=%b valid=%b ret=%0d, expected 00001234 5 1 1 1",
                     wb_data, wb_rn, wb_we, wb_valid, retired);
        end
        for (int k = 2; k < 4; k++) begin
            drive(1'b1, 1'b1, 5'(10 + k), 3'(k), 2'd2, 1'b0, 2'd0);
            step();
            exp_ret++;
            checks++;
            if (wb_data !== exp_d[k] || wb_rn !== 5'(10 + k) || retired !== exp_ret) begin
                errors++;
                $display("FAIL src_sel%0d: got data=%h rn=%0d ret=%0d, expected %h %0d %0d",
                         k, wb_data, wb_rn, retired, exp_d[k], 10 + k, exp_ret);
            end
        end
    endtask

    task automatic test_load_extract();
        // size, unsigned, offset, expected
        logic [1:0]  sz   [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
        logic        uns  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  off  [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        logic [31:0] expv [7] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_80FF, 32'h80FF_7F81,
                                  32'hFFFF_FF80, 32'h0000_7F81, 32'h80FF_7F81};
        set_srcs(32'h0000_1234, 32'h80FF_7F81, 32'h0000_0104, 32'hDEAD_BEEF);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 5'd7, 3'd1, sz[i], uns[i], off[i]);
            step();
            exp_ret++;
            checks++;
            if (wb_data !== expv[i] || wb_we !== 1'b1 || retired !== exp_ret) begin
                errors++;
                $display("FAIL load_%0d: got data=%h we=%b ret=%0d, expected %h 1 %0d",
                         i, wb_data, wb_we, retired, expv[i], exp_ret);
            end
        end
    endtask

    task automatic test_reg0();
        drive(1'b1, 1'b1, 5'd0, 3'd0, 2'd2, 1'b0, 2'd0);
        step();
        checks++;
        if (wb_we !== 1'b0 || wb_valid !== 1'b1 || retired !== exp_ret) begin
            errors++;
            $display("FAIL reg0_suppress: got we=%b valid=%b ret=%0d, expected 0 1 %0d",
                     wb_we, wb_valid, retired, exp_ret);
        end
        drive(1'b0, 1'b1, 5'd6, 3'd0, 2'd2, 1'b0, 2'd0);
        step();
        checks++;
        if (wb_we !== 1'b0 || wb_valid !== 1'b0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL invalid_no_write: got we=%b valid=%b ret=%0d, expected 0 0 %0d",
                     wb_we, wb_valid, retired, exp_ret);
        end
    endtask

    task automatic test_stall_flush();
        set_srcs(32'hAAAA_0001, 32'h80FF_7F81, 32'h0000_0104, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 5'd9, 3'd0, 2'd2, 1'b0, 2'd0);
        step();
        exp_ret++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_srcs(32'h5555_0000 + i, 32'h0, 32'h0, 32'h0);
            drive(1'b1, 1'b1, 5'(3 + i), 3'd0, 2'd2, 1'b0, 2'd0);
            step();
            checks++;
            if (wb_data !== 32'hAAAA_0001 || wb_rn !== 5'd9 || wb_we !== 1'b1 ||
                wb_valid !== 1'b1 || retired !== exp_ret) begin
                errors++;
                $display("FAIL stall_hold_%0d: got data=%h rn=%0d we=%b valid=%b ret=%0d, expected aaaa0001 9 1 1 %0d",
                         i, wb_data, wb_rn, wb_we, wb_valid, retired, exp_ret);
            end
        end
        flush = 1'b1;
        step();
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rn !== 5'd0 || wb_data !== 32'h0 ||
            retired !== exp_ret) begin
            errors++;
            $display("FAIL flush_over_stall: got valid=%b we=%b rn=%0d data=%h ret=%0d, expected 0 0 0 0 %0d",
                     wb_valid, wb_we, wb_rn, wb_data, retired, exp_ret);
        end
        stall = 1'b0;
        step();
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL flush_alone: got valid=%b we=%b ret=%0d, expected 0 0 %0d",
                     wb_valid, wb_we, retired, exp_ret);
        end
        flush = 1'b0;
    endtask

    task automatic test_illegal_sel();
        set_srcs(32'h0000_1234, 32'h80FF_7F81, 32'h0000_0104, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 5'd4, 3'd7, 2'd2, 1'b0, 2'd0);
        step();
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_invalid: got sel_err=%b, expected 0", sel_err);
        end
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd4, 3'd6, 2'd2, 1'b0, 2'd0);
        step();
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_stalled: got sel_err=%b, expected 0", sel_err);
        end
        stall = 1'b0;
        step();
        exp_ret++;
        checks++;
        if (wb_data !== 32'h0000_1234 || sel_err !== 1'b1 || wb_we !== 1'b1 ||
            retired !== exp_ret) begin
            errors++;
            $display("FAIL illegal_sel: got data=%h err=%b we=%b ret=%0d, expected 00001234 1 1 %0d",
                     wb_data, sel_err, wb_we, retired, exp_ret);
        end
        drive(1'b1, 1'b1, 5'd8, 3'd2, 2'd2, 1'b0, 2'd0);
        step();
        exp_ret++;
        checks++;
        if (wb_data !== 32'h0000_0104 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_sticky: got data=%h err=%b, expected 00000104 1",
                     wb_data, sel_err);
        end
    endtask

    task automatic test_wrap_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_before_wrap");
        @(negedge clk);
        rst = 1'b0;
        set_srcs(32'h0000_00C3, 32'h80FF_7F81, 32'h0000_0104, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 5'd1, 3'd0, 2'd2, 1'b0, 2'd0);
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00C3 || retired !== 4'd1) begin
            errors++;
            $display("FAIL first_load_after_reset: got valid=%b data=%h ret=%0d, expected 1 000000c3 1",
                     wb_valid, wb_data, retired);
        end
        for (int i = 0; i < 16; i++) step();
        checks++;
        if (retired !== 4'd1) begin
            errors++;
            $display("FAIL retired_wrap: got %0d, expected 1", retired);
        end
        // Reset mid-stall, between edges: everything clears at once.
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_stall_async");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_all_zero("stall_after_reset_discards");
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_source_select();
        test_load_extract();
        test_reg0();
        test_stall_flush();
        test_illegal_sel();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
